// File: rtl/varredura_pkg.sv
// Shared definitions for the sweep controller: state encoding and width.
`default_nettype none

package varredura_pkg;

    localparam int ESTADO_W = 3;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL  = 3'd0,
        PREPARA  = 3'd1,
        ASSENTA  = 3'd2,
        MEDE     = 3'd3,
        ARMAZENA = 3'd4,
        AVANCA   = 3'd5
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/varredura_ctrl_temporizador.sv
// temporizador_espera: wait timer with clear, count enable and terminal compare.
`default_nettype none

module temporizador_espera #(
    parameter int TW = 4
) (
    input  logic          clock,
    input  logic          zera_as_n,
    input  logic          limpa,
    input  logic          conta,
    input  logic [TW-1:0] limite,
    output logic          fim
);

    logic [TW-1:0] r_valor;

    // Clear has priority so a state exit and the next entry both see zero.
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            r_valor <= '0;
        end else if (limpa) begin
            r_valor <= '0;
        end else if (conta) begin
            r_valor <= r_valor + 1'b1;
        end
    end

    assign fim = (r_valor == limite);

endmodule

`default_nettype wire

// File: rtl/varredura_ctrl.sv
// varredura_ctrl: sweep controller - steps the position counter, settles,
// requests one measurement per position with timeout, reports round trips.
`default_nettype none

module varredura_ctrl
    import varredura_pkg::*;
#(
    parameter int T_ASSENTA = 50000,
    parameter int T_TIMEOUT = 100000,
    parameter int TW        = $clog2((T_ASSENTA > T_TIMEOUT) ? T_ASSENTA : T_TIMEOUT) + 1
) (
    input  logic                clock,
    input  logic                zera_as_n,
    input  logic                iniciar,
    input  logic                parar,
    input  logic                pos_inicio,
    input  logic                pos_fim,
    input  logic                direcao,
    input  logic                medida_pronta,
    output logic                zera_pos,
    output logic                conta_pos,
    output logic                pede_medida,
    output logic                amostra,
    output logic                ciclo_completo,
    output logic                erro_timeout,
    output logic                ocupado,
    output logic [ESTADO_W-1:0] db_estado
);

    localparam logic [TW-1:0] LIM_ASSENTA = TW'(T_ASSENTA - 1);
    localparam logic [TW-1:0] LIM_TIMEOUT = TW'(T_TIMEOUT - 1);

    estado_t       r_estado;
    logic          r_parada_pend;
    logic          r_erro;

    logic          w_fim;
    logic          w_conta;
    logic          w_limpa;
    logic          w_parada;
    logic [TW-1:0] w_limite;
    logic          w_em_mede;

    assign w_em_mede = (r_estado == MEDE);
    assign w_conta   = (r_estado == ASSENTA) || w_em_mede;
    assign w_limite  = w_em_mede ? LIM_TIMEOUT : LIM_ASSENTA;
    assign w_parada  = r_parada_pend | parar;

    // Held at zero outside the counting states and cleared on the exit edge,
    // so every counting state starts from zero.
    assign w_limpa = !w_conta
                   || ((r_estado == ASSENTA) && w_fim)
                   || (w_em_mede && (medida_pronta || w_fim));

    temporizador_espera #(
        .TW (TW)
    ) u_temporizador (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .limpa     (w_limpa),
        .conta     (w_conta),
        .limite    (w_limite),
        .fim       (w_fim)
    );

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            r_estado      <= INICIAL;
            r_parada_pend <= 1'b0;
            r_erro        <= 1'b0;
        end else begin
            if (((r_estado == ARMAZENA) || (r_estado == AVANCA)) && w_parada) begin
                r_parada_pend <= 1'b0;
            end else if ((r_estado != INICIAL) && parar) begin
                r_parada_pend <= 1'b1;
            end

            case (r_estado)
                INICIAL: begin
                    if (iniciar && !parar) begin
                        r_estado <= PREPARA;
                        r_erro   <= 1'b0;
                    end
                end
                PREPARA: r_estado <= ASSENTA;
                ASSENTA: begin
                    if (w_fim) begin
                        r_estado <= MEDE;
                    end
                end
                MEDE: begin
                    // An acknowledge coinciding with expiry takes the normal path.
                    if (medida_pronta) begin
                        r_estado <= ARMAZENA;
                    end else if (w_fim) begin
                        r_estado <= AVANCA;
                        r_erro   <= 1'b1;
                    end
                end
                ARMAZENA: r_estado <= w_parada ? INICIAL : AVANCA;
                AVANCA:   r_estado <= w_parada ? INICIAL : ASSENTA;
                default:  r_estado <= INICIAL;
            endcase
        end
    end

    assign zera_pos       = (r_estado == PREPARA);
    assign pede_medida    = w_em_mede;
    assign amostra        = (r_estado == ARMAZENA);
    assign conta_pos      = (r_estado == AVANCA);
    assign ciclo_completo = (r_estado == AVANCA) && direcao && pos_inicio;
    assign erro_timeout   = r_erro;
    assign ocupado        = (r_estado != INICIAL);
    assign db_estado      = r_estado;

    // The end-of-range flag is not needed for sequencing; the counter turns itself.
    logic w_nao_usado;
    assign w_nao_usado = pos_fim;

endmodule

`default_nettype wire

// File: tb/tb_varredura_ctrl.sv
// Directed bench for varredura_ctrl with a behavioural up/down position counter (M=4).
`default_nettype none

module tb_varredura_ctrl;

    logic       clock = 1'b0;
    logic       zera_as_n;
    logic       cnt_rst_n;
    logic       iniciar, parar, medida_pronta;
    logic       pos_inicio, pos_fim, direcao;
    logic       zera_pos, conta_pos, pede_medida, amostra;
    logic       ciclo_completo, erro_timeout, ocupado;
    logic [2:0] db_estado;

    logic [1:0] pos;
    logic       dir;

    int checks = 0;
    int errors = 0;
    int n_amostra = 0;
    int n_ciclo = 0;

    always #5 clock = ~clock;

    varredura_ctrl #(
        .T_ASSENTA (4),
        .T_TIMEOUT (8)
    ) dut (
        .clock          (clock),
        .zera_as_n      (zera_as_n),
        .iniciar        (iniciar),
        .parar          (parar),
        .pos_inicio     (pos_inicio),
        .pos_fim        (pos_fim),
        .direcao        (direcao),
        .medida_pronta  (medida_pronta),
        .zera_pos       (zera_pos),
        .conta_pos      (conta_pos),
        .pede_medida    (pede_medida),
        .amostra        (amostra),
        .ciclo_completo (ciclo_completo),
        .erro_timeout   (erro_timeout),
        .ocupado        (ocupado),
        .db_estado      (db_estado)
    );

    // Position counter model, independent of the controller reset.
    always_ff @(posedge clock or negedge cnt_rst_n) begin
        if (!cnt_rst_n) begin
            pos <= 2'd0;
            dir <= 1'b0;
        end else if (zera_pos) begin
            pos <= 2'd0;
            dir <= 1'b0;
        end else if (conta_pos) begin
            if (!dir) begin
                if (pos == 2'd3) begin
                    dir <= 1'b1;
                    pos <= 2'd2;
                end else begin
                    pos <= pos + 2'd1;
                end
            end else begin
                if (pos == 2'd0) begin
                    dir <= 1'b0;
                    pos <= 2'd1;
                end else begin
                    pos <= pos - 2'd1;
                end
            end
        end
    end

    assign pos_inicio = (pos == 2'd0);
    assign pos_fim    = (pos == 2'd3);
    assign direcao    = dir;

    always @(negedge clock) begin
        if (amostra) n_amostra++;
        if (ciclo_completo) n_ciclo++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_pede(input int lim);
        int n = 0;
        while (!pede_medida && n < lim) begin
            @(negedge clock);
            n++;
        end
        chk("wait_pede", {31'd0, pede_medida}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_pos[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
        int n;
        logic [1:0] pos_antes;

        zera_as_n = 1'b0;
        cnt_rst_n = 1'b0;
        iniciar = 1'b0;
        parar = 1'b0;
        medida_pronta = 1'b0;
        nclk(2);
        chk("rst_estado", {29'd0, db_estado}, 32'd0);
        chk("rst_saidas", {26'd0, zera_pos, conta_pos, pede_medida, amostra, erro_timeout, ocupado}, 32'd0);
        zera_as_n = 1'b1;
        cnt_rst_n = 1'b1;
        nclk(1);

        // iniciar together with parar is ignored
        iniciar = 1'b1;
        parar = 1'b1;
        nclk(1);
        iniciar = 1'b0;
        parar = 1'b0;
        chk("ini_par_estado", {29'd0, db_estado}, 32'd0);
        chk("ini_par_ocupado", {31'd0, ocupado}, 32'd0);
        nclk(1);

        // Start: edge k samples iniciar
        iniciar = 1'b1;
        nclk(1);
        iniciar = 1'b0;
        chk("k1_prepara", {29'd0, db_estado}, 32'd1);
        chk("k1_zera_pos", {31'd0, zera_pos}, 32'd1);
        nclk(1);
        chk("k2_assenta", {29'd0, db_estado}, 32'd2);
        chk("k2_zera_pos", {31'd0, zera_pos}, 32'd0);
        nclk(3);
        chk("k5_pede", {31'd0, pede_medida}, 32'd0);
        nclk(1);
        chk("k6_pede", {31'd0, pede_medida}, 32'd1);

        // Sweep: ack two cycles after each request rise
        for (int p = 0; p < 8; p++) begin
            wait_pede(20);
            chk("sweep_pos", {30'd0, pos}, exp_pos[p]);
            nclk(2);
            medida_pronta = 1'b1;
            nclk(1);
            medida_pronta = 1'b0;
            chk("sweep_amostra", {31'd0, amostra}, 32'd1);
            chk("sweep_pede_low", {31'd0, pede_medida}, 32'd0);
            nclk(1);
            chk("sweep_conta", {31'd0, conta_pos}, 32'd1);
            chk("sweep_ciclo", {31'd0, ciclo_completo}, (p == 6) ? 32'd1 : 32'd0);
            nclk(1);
            chk("sweep_assenta", {29'd0, db_estado}, 32'd2);
            if (p == 1) begin
                iniciar = 1'b1;
                nclk(1);
                iniciar = 1'b0;
                chk("busy_iniciar", {29'd0, db_estado}, 32'd2);
            end
        end
        chk("sweep_n_amostra", n_amostra, 32'd8);
        chk("sweep_n_ciclo", n_ciclo, 32'd1);

        // Stop during MEDE: handshake finishes, then idle
        wait_pede(20);
        parar = 1'b1;
        nclk(1);
        parar = 1'b0;
        chk("stop_still_mede", {29'd0, db_estado}, 32'd3);
        nclk(1);
        medida_pronta = 1'b1;
        nclk(1);
        medida_pronta = 1'b0;
        chk("stop_amostra", {31'd0, amostra}, 32'd1);
        pos_antes = pos;
        nclk(1);
        chk("stop_estado", {29'd0, db_estado}, 32'd0);
        chk("stop_ocupado", {31'd0, ocupado}, 32'd0);
        chk("stop_conta", {31'd0, conta_pos}, 32'd0);
        nclk(1);
        chk("stop_pos", {30'd0, pos}, {30'd0, pos_antes});

        // Timeout: no acknowledge
        iniciar = 1'b1;
        nclk(1);
        iniciar = 1'b0;
        wait_pede(20);
        n = 0;
        while (pede_medida && n < 20) begin
            n++;
            nclk(1);
        end
        chk("to_pede_len", n, 32'd8);
        chk("to_conta", {31'd0, conta_pos}, 32'd1);
        chk("to_amostra", {31'd0, amostra}, 32'd0);
        chk("to_erro", {31'd0, erro_timeout}, 32'd1);
        parar = 1'b1;
        nclk(1);
        parar = 1'b0;
        chk("to_idle", {29'd0, db_estado}, 32'd0);
        chk("to_erro_sticky", {31'd0, erro_timeout}, 32'd1);
        iniciar = 1'b1;
        nclk(1);
        iniciar = 1'b0;
        chk("restart_prepara", {29'd0, db_estado}, 32'd1);
        chk("restart_erro_clr", {31'd0, erro_timeout}, 32'd0);

        // Acknowledge on the last MEDE cycle wins over timeout
        wait_pede(20);
        nclk(7);
        medida_pronta = 1'b1;
        nclk(1);
        medida_pronta = 1'b0;
        chk("coinc_estado", {29'd0, db_estado}, 32'd4);
        chk("coinc_amostra", {31'd0, amostra}, 32'd1);
        chk("coinc_erro", {31'd0, erro_timeout}, 32'd0);
        nclk(2);
        chk("coinc_erro_late", {31'd0, erro_timeout}, 32'd0);
        chk("total_amostra", n_amostra, 32'd10);

        // Second timeout, then reset in the middle of MEDE
        wait_pede(20);
        nclk(8);
        chk("to2_erro", {31'd0, erro_timeout}, 32'd1);
        wait_pede(20);
        nclk(1);
        pos_antes = pos;
        zera_as_n = 1'b0;
        nclk(1);
        chk("rstm_estado", {29'd0, db_estado}, 32'd0);
        chk("rstm_pede", {31'd0, pede_medida}, 32'd0);
        chk("rstm_erro", {31'd0, erro_timeout}, 32'd0);
        chk("rstm_pos", {30'd0, pos}, {30'd0, pos_antes});
        zera_as_n = 1'b1;
        nclk(2);
        chk("rstm_idle", {31'd0, ocupado}, 32'd0);
        chk("rstm_pos_hold", {30'd0, pos}, {30'd0, pos_antes});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
